// File: rtl/vector_cmd_sequencer.sv
// Command FIFO and issue sequencer feeding the beam control stage.
// Pops packed vector commands and presents one jump/draw strobe per ready window.
module vector_cmd_sequencer #(
    parameter int ADDR_W  = 6,
    parameter int FRAME_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [25:0]        wr_data,
    output logic               full,
    output logic               empty,
    output logic [ADDR_W:0]    count,
    output logic               overflow,
    input  logic               enable,
    input  logic               ctl_ready,
    output logic               jump,
    output logic               draw,
    output logic [11:0]        x,
    output logic [11:0]        y,
    output logic               frame_done,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_JUMP  = 2'd1;
    localparam logic [1:0] OP_DRAW  = 2'd2;
    localparam logic [1:0] OP_FRAME = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    logic [25:0]        mem_r [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_r;
    logic [ADDR_W-1:0]  rd_ptr_r;
    logic [ADDR_W:0]    count_r;
    logic               full_r;
    logic               empty_r;
    logic               overflow_r;
    state_t             state_r;
    logic               jump_r;
    logic               draw_r;
    logic [11:0]        x_r;
    logic [11:0]        y_r;
    logic               frame_done_r;
    logic [FRAME_W-1:0] frame_count_r;

    logic [25:0]        head_s;
    logic [1:0]         op_s;
    logic               pop_s;
    logic               push_s;
    logic               ovf_set_s;
    logic [ADDR_W:0]    count_nxt_s;

    assign head_s = mem_r[rd_ptr_r];
    assign op_s   = head_s[25:24];

    // Pop/push qualification and next occupancy
    always_comb begin
        pop_s       = 1'b0;
        push_s      = 1'b0;
        ovf_set_s   = 1'b0;
        count_nxt_s = count_r;
        if ((state_r == ST_IDLE) && enable && !empty_r) begin
            // NOPs drain without waiting on the control stage
            if (op_s == OP_NOP) begin
                pop_s = 1'b1;
            end else begin
                pop_s = ctl_ready;
            end
        end else begin
            pop_s = 1'b0;
        end
        push_s    = wr_en && (!full_r || pop_s);
        ovf_set_s = wr_en && full_r && !pop_s;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 1'b1;
            2'b01:   count_nxt_s = count_r - 1'b1;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage write port (no reset; occupancy tracking marks validity)
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            count_r    <= {(ADDR_W + 1){1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == FULL_CNT);
            empty_r <= (count_nxt_s == {(ADDR_W + 1){1'b0}});
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Issue state machine with registered strobes and coordinates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            jump_r        <= 1'b0;
            draw_r        <= 1'b0;
            x_r           <= 12'h000;
            y_r           <= 12'h000;
            frame_done_r  <= 1'b0;
            frame_count_r <= {FRAME_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    jump_r       <= 1'b0;
                    draw_r       <= 1'b0;
                    frame_done_r <= 1'b0;
                    if (pop_s) begin
                        case (op_s)
                            OP_JUMP: begin
                                x_r     <= head_s[23:12];
                                y_r     <= head_s[11:0];
                                jump_r  <= 1'b1;
                                state_r <= ST_HOLD;
                            end
                            OP_DRAW: begin
                                x_r     <= head_s[23:12];
                                y_r     <= head_s[11:0];
                                draw_r  <= 1'b1;
                                state_r <= ST_HOLD;
                            end
                            OP_FRAME: begin
                                frame_done_r  <= 1'b1;
                                frame_count_r <= frame_count_r + 1'b1;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                // Control stage samples the strobe this cycle; ready is ignored
                ST_HOLD: begin
                    jump_r       <= 1'b0;
                    draw_r       <= 1'b0;
                    frame_done_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    jump_r       <= 1'b0;
                    draw_r       <= 1'b0;
                    frame_done_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign full        = full_r;
    assign empty       = empty_r;
    assign count       = count_r;
    assign overflow    = overflow_r;
    assign jump        = jump_r;
    assign draw        = draw_r;
    assign x           = x_r;
    assign y           = y_r;
    assign frame_done  = frame_done_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_vector_cmd_sequencer.sv
// Self-checking bench: vector table, corner-case sequences and randomized traffic
// compared against a queue-based model of the command stream.
module tb_vector_cmd_sequencer;

    localparam int AW    = 6;
    localparam int FW    = 4;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [25:0]   wr_data = 26'd0;
    logic          enable = 1'b0;
    logic          ctl_ready = 1'b0;
    logic          full, empty, overflow, jump, draw, frame_done;
    logic [AW:0]   count;
    logic [11:0]   x, y;
    logic [FW-1:0] frame_count;

    vector_cmd_sequencer #(.ADDR_W(AW), .FRAME_W(FW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .enable(enable), .ctl_ready(ctl_ready), .jump(jump), .draw(draw),
        .x(x), .y(y), .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of pending commands plus observable outputs
    logic [25:0]   mq[$];
    logic          m_hold, m_jump, m_draw, m_fd, m_ovf;
    logic [11:0]   m_x, m_y;
    logic [FW-1:0] m_fc;

    typedef struct {
        logic        wr_en;
        logic [25:0] wr_data;
        logic        enable;
        logic        ctl_ready;
        logic        exp_jump;
        logic        exp_draw;
        logic [11:0] exp_x;
        logic [11:0] exp_y;
        logic        exp_fd;
        logic [3:0]  exp_fc;
        logic [6:0]  exp_count;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [25:0] mk(input logic [1:0] op, input logic [11:0] cx, input logic [11:0] cy);
        return {op, cx, cy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_hold = 1'b0; m_jump = 1'b0; m_draw = 1'b0; m_fd = 1'b0; m_ovf = 1'b0;
        m_x = 12'h000; m_y = 12'h000; m_fc = '0;
    endtask

    // Advance the model by one clock using the inputs about to be sampled
    task automatic model_step();
        logic [25:0] h;
        bit was_full, pop;
        was_full = (mq.size() == DEPTH);
        pop = 1'b0;
        if (!m_hold && enable && mq.size() != 0) begin
            h = mq[0];
            pop = (h[25:24] == 2'd0) || ctl_ready;
        end
        m_jump = 1'b0; m_draw = 1'b0; m_fd = 1'b0; m_hold = 1'b0;
        if (pop) begin
            h = mq.pop_front();
            case (h[25:24])
                2'd1: begin m_jump = 1'b1; m_x = h[23:12]; m_y = h[11:0]; m_hold = 1'b1; end
                2'd2: begin m_draw = 1'b1; m_x = h[23:12]; m_y = h[11:0]; m_hold = 1'b1; end
                2'd3: begin m_fd = 1'b1; m_fc = m_fc + 1'b1; end
                default: ;
            endcase
        end
        if (wr_en) begin
            if (was_full && !pop) m_ovf = 1'b1;
            else mq.push_back(wr_data);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_jump"}, jump, m_jump);
        chk({tag, "_draw"}, draw, m_draw);
        chk({tag, "_x"}, x, m_x);
        chk({tag, "_y"}, y, m_y);
        chk({tag, "_fdone"}, frame_done, m_fd);
        chk({tag, "_fcount"}, frame_count, m_fc);
        chk({tag, "_count"}, count, mq.size());
        chk({tag, "_full"}, full, mq.size() == DEPTH);
        chk({tag, "_empty"}, empty, mq.size() == 0);
        chk({tag, "_ovf"}, overflow, m_ovf);
        chk({tag, "_excl"}, jump & draw, 1'b0);
    endtask

    task automatic do_reset();
        wr_en = 1'b0; enable = 1'b0; ctl_ready = 1'b0; wr_data = 26'd0;
        reset = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
    endtask

    int pulses, t_jump, t_draw, since, p_wr;

    initial begin
        vecs[0]  = '{1'b1, mk(2'd1, 12'h100, 12'h200), 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 4'd0, 7'd1};
        vecs[1]  = '{1'b0, 26'd0,                      1'b1, 1'b1, 1'b1, 1'b0, 12'h100, 12'h200, 1'b0, 4'd0, 7'd0};
        vecs[2]  = '{1'b0, 26'd0,                      1'b1, 1'b1, 1'b0, 1'b0, 12'h100, 12'h200, 1'b0, 4'd0, 7'd0};
        vecs[3]  = '{1'b1, mk(2'd2, 12'hFFF, 12'h000), 1'b1, 1'b0, 1'b0, 1'b0, 12'h100, 12'h200, 1'b0, 4'd0, 7'd1};
        vecs[4]  = '{1'b0, 26'd0,                      1'b1, 1'b0, 1'b0, 1'b0, 12'h100, 12'h200, 1'b0, 4'd0, 7'd1};
        vecs[5]  = '{1'b0, 26'd0,                      1'b1, 1'b1, 1'b0, 1'b1, 12'hFFF, 12'h000, 1'b0, 4'd0, 7'd0};
        vecs[6]  = '{1'b1, mk(2'd0, 12'h001, 12'h002), 1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF, 12'h000, 1'b0, 4'd0, 7'd1};
        vecs[7]  = '{1'b1, mk(2'd0, 12'h003, 12'h004), 1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF, 12'h000, 1'b0, 4'd0, 7'd1};
        vecs[8]  = '{1'b1, mk(2'd3, 12'h000, 12'h000), 1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF, 12'h000, 1'b0, 4'd0, 7'd1};
        vecs[9]  = '{1'b0, 26'd0,                      1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF, 12'h000, 1'b0, 4'd0, 7'd1};
        vecs[10] = '{1'b0, 26'd0,                      1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, 12'h000, 1'b1, 4'd1, 7'd0};
        vecs[11] = '{1'b0, 26'd0,                      1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, 12'h000, 1'b0, 4'd1, 7'd0};
        vecs[12] = '{1'b1, mk(2'd1, 12'h123, 12'h456), 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF, 12'h000, 1'b0, 4'd1, 7'd1};
        vecs[13] = '{1'b0, 26'd0,                      1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF, 12'h000, 1'b0, 4'd1, 7'd1};
        vecs[14] = '{1'b0, 26'd0,                      1'b1, 1'b1, 1'b1, 1'b0, 12'h123, 12'h456, 1'b0, 4'd1, 7'd0};

        do_reset();
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 7'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_strobes", {jump, draw, frame_done}, 3'b000);
        chk("rst_xy", {x, y}, 24'h000000);
        chk("rst_fcount", frame_count, 4'd0);

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data;
            enable = vecs[i].enable; ctl_ready = vecs[i].ctl_ready;
            tick();
            chk($sformatf("vec%0d_jump", i), jump, vecs[i].exp_jump);
            chk($sformatf("vec%0d_draw", i), draw, vecs[i].exp_draw);
            chk($sformatf("vec%0d_x", i), x, vecs[i].exp_x);
            chk($sformatf("vec%0d_y", i), y, vecs[i].exp_y);
            chk($sformatf("vec%0d_fdone", i), frame_done, vecs[i].exp_fd);
            chk($sformatf("vec%0d_fcount", i), frame_count, vecs[i].exp_fc);
            chk($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("hold10_xy", {x, y}, 24'h123456);
        chk("hold10_empty", empty, 1'b1);

        // JUMP then DRAW with control stage busy for 5 cycles after each strobe
        do_reset();
        enable = 1'b1; since = 100; t_jump = -1; t_draw = -1;
        for (int i = 0; i < 25; i++) begin
            wr_en = (i < 2);
            wr_data = (i == 0) ? mk(2'd1, 12'h010, 12'h020) : mk(2'd2, 12'hFFF, 12'h000);
            ctl_ready = (since == 0) || (since > 5);
            tick();
            since++;
            check_all("gap");
            if (jump) begin t_jump = i; since = 0; end
            if (draw) begin
                t_draw = i; since = 0;
                chk("gap_draw_xy", {x, y}, 24'hFFF000);
            end
        end
        chk("gap_seen", (t_jump >= 0) && (t_draw >= 0), 1'b1);
        chk("gap_min7", (t_draw - t_jump) >= 7, 1'b1);

        // Fill to full, pop+push at full, then overflow
        do_reset();
        enable = 1'b1; ctl_ready = 1'b0; wr_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_data = mk(2'd1, i[11:0], 12'hA00);
            tick();
        end
        chk("fill_full", full, 1'b1);
        chk("fill_count", count, 7'd64);
        chk("fill_ovf", overflow, 1'b0);
        ctl_ready = 1'b1; wr_data = mk(2'd2, 12'h777, 12'h888);
        tick();
        check_all("popush_full");
        chk("popush_ovf0", overflow, 1'b0);
        ctl_ready = 1'b0;
        tick();
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_count", count, 7'd64);
        tick();
        chk("ovf_count2", count, 7'd64);
        ctl_ready = 1'b1;
        tick();
        chk("popush_ovf_kept", overflow, 1'b1);
        chk("popush_count", count, 7'd64);
        check_all("full_tail");

        // Frame counter wrap with FRAME_W=4
        do_reset();
        enable = 1'b1; ctl_ready = 1'b1; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            wr_en = (i < 16); wr_data = mk(2'd3, 12'h000, 12'h000);
            tick();
            check_all("wrap");
            if (frame_done) pulses++;
        end
        chk("wrap_pulses", pulses, 16);
        chk("wrap_fcount", frame_count, 4'd0);

        // Reset asserted during HOLD with entries queued
        do_reset();
        enable = 1'b1; ctl_ready = 1'b0; wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = mk(2'd1, 12'h300 + i[11:0], 12'h400);
            tick();
        end
        wr_en = 1'b0; ctl_ready = 1'b1;
        tick();
        chk("pre_rst_jump", jump, 1'b1);
        chk("pre_rst_count", count, 7'd3);
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_rst_jump", jump, 1'b0);
        chk("async_rst_count", count, 7'd0);
        chk("async_rst_empty", empty, 1'b1);
        chk("async_rst_xy", {x, y}, 24'h000000);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_all("post_rst");
        end

        // Randomized traffic against the model
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            p_wr = (seg % 4 == 0) ? 20 : (seg % 4 == 1) ? 50 : (seg % 4 == 2) ? 90 : 70;
            for (int i = 0; i < 400; i++) begin
                wr_en = ($urandom_range(99) < p_wr);
                wr_data = {2'($urandom_range(3)), 12'($urandom), 12'($urandom)};
                enable = ($urandom_range(99) < 85);
                ctl_ready = ($urandom_range(99) < ((seg >= 4) ? 15 : 50));
                tick();
                check_all("rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_cmd_sequencer.md
Name: vector_cmd_sequencer

Overview:
Command FIFO plus issue sequencer that sits directly upstream of the beam control stage. A host-side writer (command decoder) pushes packed vector commands. The sequencer pops them and presents jump/draw strobes with held x/y coordinates, one command per control-stage ready window. It also handles NOP and end-of-frame markers and reports frame completion.

Parameters:
ADDR_W, 6, FIFO address width; depth = 2**ADDR_W entries
FRAME_W, 16, width of frame counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
wr_en  input  1  push wr_data this cycle
wr_data  input  26  {op[25:24], x[23:12], y[11:0]}; op 0=NOP, 1=JUMP, 2=DRAW, 3=FRAME_END
full  output  1  FIFO holds 2**ADDR_W entries
empty  output  1  FIFO holds 0 entries
count  output  ADDR_W+1  current occupancy
overflow  output  1  sticky: push attempted while full
enable  input  1  0 pauses popping; in-flight strobe still completes
ctl_ready  input  1  control stage idle and able to accept a command
jump  output  1  one-cycle jump strobe to control stage
draw  output  1  one-cycle draw strobe to control stage
x  output  12  target x, registered, held until next JUMP/DRAW issue
y  output  12  target y, registered, held until next JUMP/DRAW issue
frame_done  output  1  one-cycle pulse when FRAME_END retired
frame_count  output  FRAME_W  FRAME_END count, wraps modulo 2**FRAME_W

Behaviour:
- Reset (reset=0, async): pointers and count cleared. empty=1, full=0, overflow=0. jump=draw=frame_done=0. x=y=0, frame_count=0. State IDLE. Reset mid-issue drops the strobe immediately and flushes the FIFO.
- FIFO: synchronous write; entry readable the cycle after push (no fall-through). Push while full is ignored, sets overflow, and leaves count unchanged. Push and pop in the same cycle is allowed: count unchanged. When full, a simultaneous pop+push succeeds and overflow stays 0. Pointers wrap modulo depth.
- State machine: IDLE, HOLD.
- IDLE, enable=1, empty=0, head op:
  - NOP: popped regardless of ctl_ready. No outputs change. Stays IDLE, so at most one pop per cycle.
  - JUMP/DRAW: popped only when ctl_ready=1. On that edge: x,y <= head x,y; jump (or draw) <= 1; state <= HOLD.
  - FRAME_END: popped only when ctl_ready=1, so all prior vectors have finished. frame_done <= 1; frame_count <= frame_count+1; stays IDLE.
- HOLD: exactly one cycle. The strobe is high and x/y are valid in the same cycle. ctl_ready is ignored, because the control stage still shows ready while it samples the strobe. Next edge: strobe <= 0, state <= IDLE. The control stage deasserts ready by then.
- Latency: ctl_ready high with a valid head in cycle N gives strobe high in cycle N+1. The earliest next issue is from IDLE evaluation in cycle N+2.
- jump and draw are never high together. Strobes and frame_done are each high for exactly one cycle per command.
- enable=0: no pops; x/y hold; a HOLD in progress completes normally.
- empty while IDLE: outputs hold, no strobes.

Test Plan:
- Reset then push JUMP(x=0x100,y=0x200) with ctl_ready=1 -> jump high for exactly 1 cycle, 2 cycles after push, with x=0x100, y=0x200; x/y still 0x100/0x200 ten cycles later; empty=1.
- Push JUMP(0x010,0x020), DRAW(0xFFF,0x000) with ctl_ready modelled as low for 5 cycles after each strobe -> jump pulse, then draw pulse ≥7 cycles later; draw x=0xFFF, y=0x000; jump never overlaps draw.
- Push NOP, NOP, FRAME_END with ctl_ready=0 -> both NOPs drained within 2 cycles; FRAME_END waits; raising ctl_ready -> single frame_done pulse, frame_count=1.
- Push 65 entries back-to-back with ctl_ready=0, ADDR_W=6 -> full=1 at count=64, overflow=1, count stays 64. Pop+push together when full -> count 64, overflow unchanged.
- frame_count preset near wrap (FRAME_W=4, 16 FRAME_ENDs) -> frame_count returns to 0; 16 frame_done pulses.
- Assert reset=0 during HOLD with 3 entries queued -> jump drops asynchronously, count=0, empty=1, x=y=0; after release no strobe occurs without new pushes.
